// File: rtl/adc_sample_sequencer_if.sv
// rtl/adc_sample_sequencer_if.sv - ADC conversion handshake and sample output stream bundle
interface adc_sample_sequencer_if #(
  parameter int DATA_W = 12
);
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - tick-driven ADC conversion sequencer with FWFT sample FIFO
module adc_sample_sequencer #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_in,
  input  logic                      en,
  adc_sample_sequencer_if.master    bus,
  output logic [$clog2(DEPTH):0]    level,
  input  logic                      clr_flags,
  output logic                      ovf,
  output logic                      miss,
  output logic                      tmo
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state;
  logic              tick_d;
  logic              tick_edge;
  logic [CW-1:0]     tmo_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              done_ev;
  logic              push;
  logic              drop;
  logic              pop;
  logic              expire;
  logic              miss_ev;

  assign tick_edge = tick_in & ~tick_d;
  assign done_ev   = (state == S_WAIT) & bus.adc_done;
  // Fullness comes from the registered level, so a same-cycle pop never makes room.
  assign push      = done_ev & (level != FULL);
  assign drop      = done_ev & (level == FULL);
  assign expire    = (state == S_WAIT) & ~bus.adc_done & (tmo_cnt == TMO_LAST);
  assign miss_ev   = tick_edge & (state != S_IDLE);
  assign pop       = bus.out_valid & bus.out_ready;

  assign bus.out_valid = (level != '0);
  assign bus.out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.adc_start <= 1'b0;
      tick_d        <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      tick_d        <= tick_in;
      bus.adc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick_edge & en) begin
            state         <= S_START;
            bus.adc_start <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (bus.adc_done || expire) begin
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.adc_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf  <= 1'b0;
      miss <= 1'b0;
      tmo  <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (miss_ev) miss <= 1'b1;
      else if (clr_flags) miss <= 1'b0;
      if (expire) tmo <= 1'b1;
      else if (clr_flags) tmo <= 1'b0;
    end
  end
endmodule
